reservation_station: RTL and testbench

- Per-FU reservation station sitting directly downstream of the scoreboard's issue port and upstream of its read-request port.
- Buffers renamed ops: issue_dst_reg_rename / issue_src*_rename plus an opcode.
- Selects the oldest entry whose sources are not write-pending and presents it on the fu2sb_read_* handshake.
- On acceptance, hands the op to the FU execute stage through a one-entry output register.
- Drives fu_available and reg_read_pending back into the scoreboard.

---
 rtl/reservation_station_pkg.sv | 24 ++
 rtl/decode.sv | 16 +
 rtl/leading_zero_one_cnt.sv | 23 ++
 rtl/reservation_station.sv | 148 ++++++++++++++
 tb/tb_reservation_station.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/reservation_station_pkg.sv
// Shared types and sizing for the reservation station, extending the scoreboard's register and opcode widths.
package reservation_station_pkg;

    localparam int NUM_REG       = 8;
    localparam int REG_ID_BIT    = $clog2(NUM_REG);
    localparam int OP_BIT        = 4;
    localparam int RS_NUM_ENTRY  = 4;

    typedef struct packed {
        logic [OP_BIT-1:0]     op;
        logic [REG_ID_BIT-1:0] dst;
        logic [REG_ID_BIT-1:0] src0;
        logic [REG_ID_BIT-1:0] src1;
    } rs_entry_t;

    // A source blocks only while its producer is outstanding; register 0 and
    // a source that is the op's own destination never block.
    function automatic logic src_clear(input logic [REG_ID_BIT-1:0] src,
                                       input logic [REG_ID_BIT-1:0] dst,
                                       input logic [NUM_REG-1:0]    write_pending);
        return (src == '0) || !write_pending[src] || (src == dst);
    endfunction

endpackage

// File: rtl/decode.sv
// Binary-to-one-hot decoder shared across the scoreboard slice.
module decode #(
    parameter int IN_BIT  = 3,
    parameter int OUT_BIT = 1 << IN_BIT
) (
    input  logic [IN_BIT-1:0]  in_i,
    output logic [OUT_BIT-1:0] out_o
);

    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        out_o       = '0;
        out_o[in_i] = 1'b1;
    end

endmodule

// File: rtl/leading_zero_one_cnt.sv
// Scans from bit 0 upward: COUNT_ZERO=0 returns the index of the first set bit, COUNT_ZERO=1 the first clear bit.
module leading_zero_one_cnt #(
    parameter int  WIDTH      = 4,
    parameter bit  COUNT_ZERO = 1'b0,
    localparam int CNT_BIT    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]   vec_i,
    output logic [CNT_BIT-1:0] cnt_o,
    output logic               found_o
);

    always_comb begin
        cnt_o   = '0;
        found_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i] != COUNT_ZERO) begin
                cnt_o   = CNT_BIT'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Per-FU reservation station: compacting age queue, oldest-ready select onto the
// scoreboard read port, and a one-entry output register feeding the execute stage.
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int  NUM_ENTRY = RS_NUM_ENTRY,
    localparam int CNT_BIT   = $clog2(NUM_ENTRY + 1),
    localparam int IDX_BIT   = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_vld,
    output logic                  issue_rdy,
    input  logic [OP_BIT-1:0]     issue_op,
    input  logic [REG_ID_BIT-1:0] issue_dst,
    input  logic [REG_ID_BIT-1:0] issue_src0,
    input  logic [REG_ID_BIT-1:0] issue_src1,
    output logic                  fu_available,
    input  logic [NUM_REG-1:0]    reg_write_pending,
    output logic [NUM_REG-1:0]    reg_read_pending,
    output logic                  rd_vld,
    input  logic                  rd_rdy,
    output logic [REG_ID_BIT-1:0] rd_reg0,
    output logic [REG_ID_BIT-1:0] rd_reg1,
    output logic [REG_ID_BIT-1:0] rd_wr_nxt,
    output logic                  ex_vld,
    input  logic                  ex_rdy,
    output logic [OP_BIT-1:0]     ex_op,
    output logic [REG_ID_BIT-1:0] ex_dst,
    output logic [CNT_BIT-1:0]    occupancy
);

    rs_entry_t             entry_q [NUM_ENTRY];
    rs_entry_t             entry_d [NUM_ENTRY];
    logic [CNT_BIT-1:0]    occ_q, occ_d;
    logic                  ex_vld_q, ex_vld_d;
    logic [OP_BIT-1:0]     ex_op_q, ex_op_d;
    logic [REG_ID_BIT-1:0] ex_dst_q, ex_dst_d;

    logic [NUM_ENTRY-1:0]  valid, ready;
    logic [NUM_REG-1:0]    src0_oh [NUM_ENTRY];
    logic [NUM_REG-1:0]    src1_oh [NUM_ENTRY];
    logic [IDX_BIT-1:0]    sel_idx;
    logic                  any_ready;
    rs_entry_t             sel_entry;
    logic                  dispatch, insert;
    logic [CNT_BIT-1:0]    tail;

    for (genvar g = 0; g < NUM_ENTRY; g++) begin : g_entry
        assign valid[g] = (occ_q > CNT_BIT'(g));
        assign ready[g] = valid[g]
                        && src_clear(entry_q[g].src0, entry_q[g].dst, reg_write_pending)
                        && src_clear(entry_q[g].src1, entry_q[g].dst, reg_write_pending);

        decode #(.IN_BIT(REG_ID_BIT), .OUT_BIT(NUM_REG)) u_dec_src0 (
            .in_i (entry_q[g].src0),
            .out_o(src0_oh[g])
        );
        decode #(.IN_BIT(REG_ID_BIT), .OUT_BIT(NUM_REG)) u_dec_src1 (
            .in_i (entry_q[g].src1),
            .out_o(src1_oh[g])
        );
    end

    leading_zero_one_cnt #(.WIDTH(NUM_ENTRY), .COUNT_ZERO(1'b0)) u_oldest_ready (
        .vec_i  (ready),
        .cnt_o  (sel_idx),
        .found_o(any_ready)
    );

    // Read pending comes only from stored entries, never from the op being issued.
    always_comb begin
        reg_read_pending = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (valid[i]) reg_read_pending = reg_read_pending | src0_oh[i] | src1_oh[i];
        end
        reg_read_pending[0] = 1'b0;
    end

    assign sel_entry    = entry_q[sel_idx];
    assign issue_rdy    = (occ_q != CNT_BIT'(NUM_ENTRY));
    assign fu_available = issue_rdy;
    assign rd_vld       = any_ready && (!ex_vld_q || ex_rdy);
    assign rd_reg0      = rd_vld ? sel_entry.src0 : '0;
    assign rd_reg1      = rd_vld ? sel_entry.src1 : '0;
    assign rd_wr_nxt    = rd_vld ? sel_entry.dst  : '0;
    assign dispatch     = rd_vld && rd_rdy;
    assign insert       = issue_vld && issue_rdy;
    assign tail         = dispatch ? occ_q - CNT_BIT'(1) : occ_q;

    always_comb begin
        for (int i = 0; i < NUM_ENTRY; i++) entry_d[i] = entry_q[i];
        // Close the gap left by the dispatched entry so index order stays age order.
        for (int i = 0; i < NUM_ENTRY - 1; i++) begin
            if (dispatch && IDX_BIT'(i) >= sel_idx) entry_d[i] = entry_q[i+1];
        end
        for (int i = 0; i < NUM_ENTRY; i++) begin
            if (insert && CNT_BIT'(i) == tail) begin
                entry_d[i] = '{op: issue_op, dst: issue_dst, src0: issue_src0, src1: issue_src1};
            end
        end
    end

    always_comb begin
        occ_d    = occ_q;
        ex_vld_d = ex_vld_q;
        ex_op_d  = ex_op_q;
        ex_dst_d = ex_dst_q;
        case ({insert, dispatch})
            2'b10:   occ_d = occ_q + CNT_BIT'(1);
            2'b01:   occ_d = occ_q - CNT_BIT'(1);
            default: occ_d = occ_q;
        endcase
        if (dispatch) begin
            ex_vld_d = 1'b1;
            ex_op_d  = sel_entry.op;
            ex_dst_d = sel_entry.dst;
        end else if (ex_rdy) begin
            ex_vld_d = 1'b0;
        end
    end

    // NOTE: payload storage has no reset; validity comes from occupancy alone.
    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            occ_q    <= '0;
            ex_vld_q <= 1'b0;
            ex_op_q  <= '0;
            ex_dst_q <= '0;
        end else begin
            occ_q    <= occ_d;
            ex_vld_q <= ex_vld_d;
            ex_op_q  <= ex_op_d;
            ex_dst_q <= ex_dst_d;
        end
    end

    assign ex_vld    = ex_vld_q;
    assign ex_op     = ex_op_q;
    assign ex_dst    = ex_dst_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench: a queue-based model predicts every output; a monitor checks ops leaving to execute.
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int NE = RS_NUM_ENTRY;
    localparam int CB = $clog2(NE + 1);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  issue_vld, issue_rdy, fu_available;
    logic [OP_BIT-1:0]     issue_op;
    logic [REG_ID_BIT-1:0] issue_dst, issue_src0, issue_src1;
    logic [NUM_REG-1:0]    reg_write_pending, reg_read_pending;
    logic                  rd_vld, rd_rdy;
    logic [REG_ID_BIT-1:0] rd_reg0, rd_reg1, rd_wr_nxt;
    logic                  ex_vld, ex_rdy;
    logic [OP_BIT-1:0]     ex_op;
    logic [REG_ID_BIT-1:0] ex_dst;
    logic [CB-1:0]         occupancy;

    reservation_station dut (
        .clk(clk), .rst_n(rst_n),
        .issue_vld(issue_vld), .issue_rdy(issue_rdy), .issue_op(issue_op),
        .issue_dst(issue_dst), .issue_src0(issue_src0), .issue_src1(issue_src1),
        .fu_available(fu_available),
        .reg_write_pending(reg_write_pending), .reg_read_pending(reg_read_pending),
        .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_reg0(rd_reg0), .rd_reg1(rd_reg1),
        .rd_wr_nxt(rd_wr_nxt),
        .ex_vld(ex_vld), .ex_rdy(ex_rdy), .ex_op(ex_op), .ex_dst(ex_dst),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OP_BIT-1:0]     op;
        logic [REG_ID_BIT-1:0] dst;
    } ex_txn_t;

    int         checks   = 0;
    int         failures = 0;
    rs_entry_t  model_q[$];
    ex_txn_t    exp_ex[$];
    logic                  m_ex_vld;
    logic [OP_BIT-1:0]     m_ex_op;
    logic [REG_ID_BIT-1:0] m_ex_dst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rs_entry_t mk(input int op, input int d, input int s0, input int s1);
        return '{op: OP_BIT'(op), dst: REG_ID_BIT'(d), src0: REG_ID_BIT'(s0), src1: REG_ID_BIT'(s1)};
    endfunction

    function automatic logic blocked(input logic [REG_ID_BIT-1:0] s, input logic [REG_ID_BIT-1:0] d,
                                     input logic [NUM_REG-1:0] wp);
        return (s != 0) && wp[s] && (s != d);
    endfunction

    task automatic model_reset();
        model_q.delete();
        exp_ex.delete();
        m_ex_vld = 1'b0;
        m_ex_op  = '0;
        m_ex_dst = '0;
    endtask

    // One clock: drive inputs after the falling edge, compare every output against
    // the model, then advance the model as the coming rising edge will.
    task automatic step(input logic iv, input rs_entry_t e, input logic [NUM_REG-1:0] wp,
                        input logic rr, input logic er);
        int                 k;
        logic               exp_rdy, exp_rd_vld;
        logic [NUM_REG-1:0] exp_rrp;
        rs_entry_t          s;
        @(negedge clk);
        issue_vld = iv; issue_op = e.op; issue_dst = e.dst;
        issue_src0 = e.src0; issue_src1 = e.src1;
        reg_write_pending = wp; rd_rdy = rr; ex_rdy = er;
        #1;
        exp_rdy = (model_q.size() < NE);
        exp_rrp = '0;
        foreach (model_q[j]) begin
            exp_rrp[model_q[j].src0] = 1'b1;
            exp_rrp[model_q[j].src1] = 1'b1;
        end
        exp_rrp[0] = 1'b0;
        k = -1;
        foreach (model_q[j]) begin
            if (k < 0 && !blocked(model_q[j].src0, model_q[j].dst, wp)
                      && !blocked(model_q[j].src1, model_q[j].dst, wp)) k = j;
        end
        exp_rd_vld = (k >= 0) && (!m_ex_vld || er);
        s = exp_rd_vld ? model_q[k] : '0;
        check("issue_rdy", issue_rdy, exp_rdy);
        check("fu_available", fu_available, exp_rdy);
        check("occupancy", occupancy, model_q.size());
        check("rd_vld", rd_vld, exp_rd_vld);
        check("rd_reg0", rd_reg0, s.src0);
        check("rd_reg1", rd_reg1, s.src1);
        check("rd_wr_nxt", rd_wr_nxt, s.dst);
        check("reg_read_pending", reg_read_pending, exp_rrp);
        check("ex_vld", ex_vld, m_ex_vld);
        check("ex_op", ex_op, m_ex_op);
        check("ex_dst", ex_dst, m_ex_dst);
        if (exp_rd_vld && rr) begin
            exp_ex.push_back('{op: s.op, dst: s.dst});
            model_q.delete(k);
            m_ex_vld = 1'b1;
            m_ex_op  = s.op;
            m_ex_dst = s.dst;
        end else if (er) begin
            m_ex_vld = 1'b0;
        end
        if (iv && exp_rdy) model_q.push_back(e);
    endtask

    // Monitor: whenever the execute stage takes an op, it must be the next one dispatched.
    initial begin
        ex_txn_t t;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ex_vld && ex_rdy) begin
                if (exp_ex.size() == 0) begin
                    check("scb_unexpected_ex", 1, 0);
                end else begin
                    t = exp_ex.pop_front();
                    check("scb_ex_op", ex_op, t.op);
                    check("scb_ex_dst", ex_dst, t.dst);
                end
            end
        end
    end

    initial begin
        rs_entry_t z;
        z = mk(0, 0, 0, 0);
        rst_n = 1'b0;
        issue_vld = 0; issue_op = '0; issue_dst = '0; issue_src0 = '0; issue_src1 = '0;
        reg_write_pending = '0; rd_rdy = 0; ex_rdy = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic issue -> read -> execute
        step(1, mk(1, 3, 1, 2), '0, 1, 1);
        step(0, z, '0, 1, 1);
        check("t_basic_rd_reg0", rd_reg0, 1);
        check("t_basic_rd_wr_nxt", rd_wr_nxt, 3);
        step(0, z, '0, 1, 1);
        check("t_basic_ex_dst", ex_dst, 3);
        step(0, z, '0, 1, 1);

        // Younger ready entry overtakes an older blocked one
        step(1, mk(2, 7, 5, 0), 8'h20, 0, 1);
        step(1, mk(3, 1, 6, 0), 8'h20, 0, 1);
        step(0, z, 8'h20, 1, 1);
        check("t_ooo_first", rd_reg0, 6);
        step(0, z, 8'h20, 1, 1);
        check("t_ooo_blocked", rd_vld, 0);
        step(0, z, '0, 1, 1);
        check("t_ooo_second", rd_reg0, 5);
        step(0, z, '0, 1, 1);

        // Source equal to own destination is not a hazard
        step(1, mk(4, 4, 4, 0), 8'h10, 0, 1);
        step(0, z, 8'h10, 0, 1);
        check("t_self_rd_vld", rd_vld, 1);
        check("t_self_wr_nxt", rd_wr_nxt, 4);
        step(0, z, 8'h10, 1, 1);
        step(0, z, '0, 0, 1);

        // Full queue, dispatch from the middle, then refill at the tail
        step(1, mk(5, 2, 3, 0), 8'h08, 0, 1);
        step(1, mk(6, 3, 0, 4), 8'h08, 0, 1);
        step(1, mk(7, 4, 5, 0), 8'h08, 0, 1);
        step(1, mk(8, 5, 6, 7), 8'h08, 0, 1);
        step(1, mk(9, 6, 1, 1), 8'h08, 0, 1);
        check("t_full_issue_rdy", issue_rdy, 0);
        check("t_full_fu_available", fu_available, 0);
        check("t_full_sel_entry1", rd_reg1, 4);
        step(1, mk(9, 6, 1, 1), 8'h08, 1, 1);
        step(1, mk(10, 6, 0, 2), 8'h08, 0, 1);
        step(0, z, 8'h08, 0, 1);
        check("t_full_refilled", occupancy, NE);
        repeat (6) step(0, z, '0, 1, 1);

        // Execute backpressure, then back-to-back dispatch
        step(1, mk(1, 1, 2, 3), '0, 0, 1);
        step(1, mk(2, 2, 4, 5), '0, 0, 1);
        step(1, mk(3, 3, 6, 7), '0, 0, 1);
        step(0, z, '0, 1, 0);
        step(0, z, '0, 1, 0);
        check("t_bp_rd_vld_held", rd_vld, 0);
        repeat (4) step(0, z, '0, 1, 1);

        // Asynchronous reset with three entries and a busy output register
        repeat (4) step(1, mk(11, 2, 0, 3), '0, 0, 1);
        step(0, z, '0, 1, 0);
        step(0, z, '0, 0, 0);
        check("t_rst_pre_occ", occupancy, 3);
        check("t_rst_pre_ex_vld", ex_vld, 1);
        @(negedge clk);
        #3 rst_n = 1'b0;
        issue_vld = 0; rd_rdy = 0;
        #1;
        model_reset();
        check("t_rst_occ", occupancy, 0);
        check("t_rst_rd_vld", rd_vld, 0);
        check("t_rst_ex_vld", ex_vld, 0);
        check("t_rst_issue_rdy", issue_rdy, 1);
        check("t_rst_rrp", reg_read_pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, z, '0, 1, 1);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 3) != 0,
                 mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                 NUM_REG'($urandom_range(0, 255) & $urandom_range(0, 255)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        repeat (12) step(0, z, '0, 1, 1);
        check("scb_drained", exp_ex.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
